pixel_mem_port_arbiter: RTL and testbench
=========================================

# pixel_mem_port_arbiter

Shares port A of the dual-port pixel memory between two requesters: the pixel loader (requester 1) and the filter engine (requester 2). The block issues one access per cycle and arbitrates contention round-robin. It drives the memory wrapper's two port-A address inputs and its address select, and routes port-A read data back to the issuing requester with a valid strobe. Port B is not touched.

## Interface
Parameters:
- RD_LAT, 2: memory read latency in cycles, from the address cycle to q_a valid; legal range 1–4.
- AW, 10: address width.
- DW, 16: data width.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- req_1 / req_2  in  1  access request, requester 1 / 2
- wen_1 / wen_2  in  1  1 = write, 0 = read; qualified by req
- addr_1 / addr_2  in  AW  word address
- wdata_1 / wdata_2  in  DW  write data
- gnt_1 / gnt_2  out  1  access accepted this cycle
- rvalid_1 / rvalid_2  out  1  rdata valid for that requester
- rdata  out  DW  read data, shared; qualified by rvalid_x
- mem_addr_1  out  AW  to memory port-A address input 1 (equals addr_1)
- mem_addr_2  out  AW  to memory port-A address input 2 (equals addr_2)
- mem_select  out  1  0 selects address 1, 1 selects address 2
- mem_wdata  out  DW  to memory data_a
- mem_wren  out  1  to memory wren_a
- mem_q  in  DW  from memory q_a
- busy  out  1  a read is still in flight

## Operation
- State: `last` register (1 bit, the last granted requester) and a RD_LAT-deep tag pipeline. Each tag is {valid, owner}.
- Grant is combinational in the request cycle:
  - Only req_1 asserted: gnt_1.
  - Only req_2 asserted: gnt_2.
  - Both asserted: grant the requester that is not `last`.
- At most one gnt per cycle. A requester that is not granted holds req, addr, wen and wdata stable until it is granted.
- In the grant cycle:
  - mem_select = granted id (0 for requester 1, 1 for requester 2).
  - mem_wren = granted wen.
  - mem_wdata = granted wdata.
- With no grant: mem_wren = 0 and mem_select holds its last value (registered copy).
- `last` updates on each grant.
- A granted read pushes {1, owner} into the tag pipeline. A write or idle cycle pushes {0, x}.
- Pipeline output with valid set asserts rvalid of the tagged owner for 1 cycle. rdata = mem_q, unregistered.
- busy = OR of the tag valid bits.
- Reset (asynchronous, n_rst low):
  - `last` = 2, so requester 1 wins the first contention.
  - Tag pipeline cleared and registered select = 0.
  - While n_rst is low, gnt_x, mem_wren and rvalid_x are forced 0.
  - In-flight reads are dropped and never return a strobe.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the cycle req is sampled.
- Write commits at the rising edge that ends the grant cycle.
- Read: grant in cycle N, rvalid and rdata in cycle N+RD_LAT. Back-to-back reads return in issue order, one per cycle.
- Fully pipelined: the block sustains 1 access per cycle regardless of owner alternation.
- Read-after-write to the same address by either requester in consecutive grants returns the new data. This relies on the memory's old/new read-during-write mode being set to new data.
- Release after reset: arbitration is live from the first rising edge after n_rst deasserts.

## Configuration
- PIXEL_ARB_LOCK_EN defined:
  - Adds inputs lock_1 and lock_2.
  - If the requester granted in cycle N also has lock asserted in cycle N, it has absolute priority in cycle N+1 whenever its req is asserted.
  - The lock holds for as long as that requester keeps req and lock asserted, which allows uninterrupted bursts.
  - `last` is not updated while a lock is held.
- PIXEL_ARB_LOCK_EN undefined: no lock ports; pure round-robin as above.

## Test plan
- Reset with both reqs high -> gnt_1 = gnt_2 = 0, mem_wren = 0, busy = 0. After release, the first cycle gives gnt_1.
- Requester 1 writes 0xA5A5 to 0x3FF, then requester 2 reads 0x3FF -> rvalid_2 = 1 exactly RD_LAT cycles after gnt_2, rdata = 0xA5A5, rvalid_1 stays 0.
- Both requesters request reads continuously for 8 cycles -> grants alternate 1,2,1,2…, mem_select toggles each cycle, and rvalids return in the same alternating order with matching data.
- n_rst pulsed low 1 cycle after a read grant -> no rvalid for that read, busy = 0 after reset, and the next contention is won by requester 1.
- Run with RD_LAT = 1 and with RD_LAT = 4, issuing 4 back-to-back reads to addresses 0–3 preloaded with 0x0001–0x0004 -> 4 consecutive rvalid cycles carrying 0x0001..0x0004, with the first rvalid RD_LAT cycles after the first grant.
- With PIXEL_ARB_LOCK_EN: requester 2 holds lock while both request for 5 cycles -> gnt_2 on all 5 cycles. Dropping lock then gives gnt_1 on the next cycle.

Source files
------------

// File: rtl/pixel_mem_port_arbiter.sv
// pixel_mem_port_arbiter
// Shares port A of the dual-port pixel memory between the pixel loader
// (requester 1) and the filter engine (requester 2). It issues one access per
// cycle with round-robin arbitration and routes read data back with a per-owner
// valid strobe that arrives RD_LAT cycles after the grant.
//
// Optional feature macro: PIXEL_ARB_LOCK_EN adds lock_1/lock_2. A requester
// granted with its lock asserted keeps absolute priority for as long as it
// holds both req and lock. This allows uninterrupted bursts.
//
// Ports:
//   clk, n_rst               clock, async active-low reset
//   lock_1, lock_2           burst lock (PIXEL_ARB_LOCK_EN only)
//   req_x, wen_x             request and write enable, requester x
//   addr_x, wdata_x          request address and write data, requester x
//   gnt_x                    access accepted this cycle (combinational)
//   rvalid_x, rdata          returned read data and its owner strobe
//   mem_addr_1, mem_addr_2   port-A address inputs of the memory wrapper
//   mem_select               port-A address select (0: addr 1, 1: addr 2)
//   mem_wdata, mem_wren      port-A write data and write enable
//   mem_q                    port-A read data
//   busy                     at least one read is in flight
module pixel_mem_port_arbiter #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned AW     = 10,
    parameter int unsigned DW     = 16
) (
    input  logic          clk,
    input  logic          n_rst,
`ifdef PIXEL_ARB_LOCK_EN
    input  logic          lock_1,
    input  logic          lock_2,
`endif
    input  logic          req_1,
    input  logic          req_2,
    input  logic          wen_1,
    input  logic          wen_2,
    input  logic [AW-1:0] addr_1,
    input  logic [AW-1:0] addr_2,
    input  logic [DW-1:0] wdata_1,
    input  logic [DW-1:0] wdata_2,
    output logic          gnt_1,
    output logic          gnt_2,
    output logic          rvalid_1,
    output logic          rvalid_2,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr_1,
    output logic [AW-1:0] mem_addr_2,
    output logic          mem_select,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q,
    output logic          busy
);

    logic              last_q;   // 0: requester 1 granted last, 1: requester 2
    logic              sel_q;    // select held through idle cycles
    logic [RD_LAT-1:0] tag_v_q;  // read-tag valid pipeline
    logic [RD_LAT-1:0] tag_o_q;  // read-tag owner pipeline (1 = requester 2)
    logic              hold_1_c;
    logic              hold_2_c;
    logic              rd_push_c;

`ifdef PIXEL_ARB_LOCK_EN
    logic lock_q;
    logic lock_id_q;

    // Lock is live only while its holder keeps both req and lock asserted
    always_comb begin
        hold_1_c = 1'b0;
        hold_2_c = 1'b0;
        if (lock_q) begin
            hold_1_c = !lock_id_q && req_1 && lock_1;
            hold_2_c =  lock_id_q && req_2 && lock_2;
        end
    end

    // Lock state: armed by a grant taken with lock asserted
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else begin
            lock_q    <= (gnt_1 && lock_1) || (gnt_2 && lock_2);
            lock_id_q <= gnt_2;
        end
    end
`else
    assign hold_1_c = 1'b0;
    assign hold_2_c = 1'b0;
`endif

    // Grant: lock holder first, otherwise the requester that was not last
    always_comb begin
        gnt_1 = 1'b0;
        gnt_2 = 1'b0;
        if (req_1 && req_2) begin
            if (hold_1_c)      gnt_1 = 1'b1;
            else if (hold_2_c) gnt_2 = 1'b1;
            else if (last_q)   gnt_1 = 1'b1;
            else               gnt_2 = 1'b1;
        end else begin
            gnt_1 = req_1;
            gnt_2 = req_2;
        end
        if (!n_rst) begin
            gnt_1 = 1'b0;
            gnt_2 = 1'b0;
        end
    end

    // Memory port-A steering for the granted access
    always_comb begin
        mem_select = sel_q;
        mem_wren   = 1'b0;
        mem_wdata  = wdata_1;
        rd_push_c  = 1'b0;
        if (gnt_1) begin
            mem_select = 1'b0;
            mem_wren   = wen_1;
            rd_push_c  = !wen_1;
        end else if (gnt_2) begin
            mem_select = 1'b1;
            mem_wren   = wen_2;
            mem_wdata  = wdata_2;
            rd_push_c  = !wen_2;
        end
    end

    assign mem_addr_1 = addr_1;
    assign mem_addr_2 = addr_2;

    // Arbitration history and held select
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_q <= 1'b1;
            sel_q  <= 1'b0;
        end else begin
            sel_q <= mem_select;
            if ((gnt_1 || gnt_2) && !(hold_1_c || hold_2_c)) begin
                last_q <= gnt_2;
            end
        end
    end

    // Read-tag pipeline; stage RD_LAT-1 lines up with mem_q
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tag_v_q <= '0;
            tag_o_q <= '0;
        end else begin
            tag_v_q[0] <= rd_push_c;
            tag_o_q[0] <= gnt_2;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_o_q[i] <= tag_o_q[i-1];
            end
        end
    end

    assign rvalid_1 = n_rst && tag_v_q[RD_LAT-1] && !tag_o_q[RD_LAT-1];
    assign rvalid_2 = n_rst && tag_v_q[RD_LAT-1] &&  tag_o_q[RD_LAT-1];
    assign rdata    = mem_q;
    assign busy     = |tag_v_q;

endmodule

// File: tb/tb_pixel_mem_port_arbiter.sv
// Bench for pixel_mem_port_arbiter: three instances (RD_LAT 2, 1, 4) share one
// stimulus stream, and each has its own port-A memory model.
module tb_pixel_mem_port_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam int          N  = 3;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    logic          clk;
    logic          n_rst;
    logic          req_1, req_2, wen_1, wen_2;
    logic [AW-1:0] addr_1, addr_2;
    logic [DW-1:0] wdata_1, wdata_2;
`ifdef PIXEL_ARB_LOCK_EN
    logic          lock_1, lock_2;
`endif

    logic          gnt_1    [N];
    logic          gnt_2    [N];
    logic          rvalid_1 [N];
    logic          rvalid_2 [N];
    logic [DW-1:0] rdata    [N];
    logic [AW-1:0] maddr_1  [N];
    logic [AW-1:0] maddr_2  [N];
    logic          msel     [N];
    logic [DW-1:0] mwdata   [N];
    logic          mwren    [N];
    logic [DW-1:0] mq       [N];
    logic          busy     [N];

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned L = 32'(lat_of(g));
        logic [DW-1:0] mem  [0:(1<<AW)-1];
        logic [DW-1:0] pipe [4];
        logic [AW-1:0] ma;

        // Port A model: new-data read-during-write, L-cycle read latency
        assign ma    = msel[g] ? maddr_2[g] : maddr_1[g];
        assign mq[g] = pipe[L-1];

        always @(posedge clk) begin
            if (mwren[g]) mem[ma] <= mwdata[g];
            pipe[0] <= mwren[g] ? mwdata[g] : mem[ma];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        pixel_mem_port_arbiter #(.RD_LAT(L), .AW(AW), .DW(DW)) u_dut (
            .clk        (clk),
            .n_rst      (n_rst),
`ifdef PIXEL_ARB_LOCK_EN
            .lock_1     (lock_1),
            .lock_2     (lock_2),
`endif
            .req_1      (req_1),
            .req_2      (req_2),
            .wen_1      (wen_1),
            .wen_2      (wen_2),
            .addr_1     (addr_1),
            .addr_2     (addr_2),
            .wdata_1    (wdata_1),
            .wdata_2    (wdata_2),
            .gnt_1      (gnt_1[g]),
            .gnt_2      (gnt_2[g]),
            .rvalid_1   (rvalid_1[g]),
            .rvalid_2   (rvalid_2[g]),
            .rdata      (rdata[g]),
            .mem_addr_1 (maddr_1[g]),
            .mem_addr_2 (maddr_2[g]),
            .mem_select (msel[g]),
            .mem_wdata  (mwdata[g]),
            .mem_wren   (mwren[g]),
            .mem_q      (mq[g]),
            .busy       (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic r1, input logic w1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic r2, input logic w2,
                       input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        req_1 = r1; wen_1 = w1; addr_1 = a1; wdata_1 = d1;
        req_2 = r2; wen_2 = w2; addr_2 = a2; wdata_2 = d2;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
`ifdef PIXEL_ARB_LOCK_EN
        lock_1 = 1'b0;
        lock_2 = 1'b0;
`endif
        // Reset with both requesters asking to write
        n_rst = 1'b0;
        drv(1'b1, 1'b1, 10'd0, 16'h0001, 1'b1, 1'b1, 10'h3FF, 16'h1111);
        repeat (2) tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_gnt1_%0d", i), 32'(gnt_1[i]), 32'd0);
            chk($sformatf("rst_gnt2_%0d", i), 32'(gnt_2[i]), 32'd0);
            chk($sformatf("rst_wren_%0d", i), 32'(mwren[i]), 32'd0);
            chk($sformatf("rst_busy_%0d", i), 32'(busy[i]), 32'd0);
        end

        // First contention after release goes to requester 1
        tick();
        n_rst = 1'b1;
        @(negedge clk);
        chk("first_gnt1", 32'(gnt_1[0]), 32'd1);
        chk("first_gnt2", 32'(gnt_2[0]), 32'd0);
        chk("first_wren", 32'(mwren[0]), 32'd1);
        chk("first_sel",  32'(msel[0]),  32'd0);
        tick();
        drv(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h3FF, 16'h1111);
        @(negedge clk);
        chk("held_gnt2", 32'(gnt_2[0]), 32'd1);
        chk("held_sel",  32'(msel[0]),  32'd1);

        // Preload addresses 1..3 with 2..4 (address 0 already holds 1)
        for (int a = 1; a < 4; a++) begin
            tick();
            drv(1'b1, 1'b1, AW'(a), DW'(a + 1), 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            chk($sformatf("pre_gnt1_%0d", a), 32'(gnt_1[0]), 32'd1);
        end

        // Requester 1 writes 0xA5A5 to 0x3FF, requester 2 reads it back
        tick();
        drv(1'b1, 1'b1, 10'h3FF, 16'hA5A5, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("raw_wr_wren", 32'(mwren[0]), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) drv(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h3FF, '0);
            else        idle();
            @(negedge clk);
            if (k == 0) begin
                chk("raw_gnt2", 32'(gnt_2[0]), 32'd1);
                chk("raw_rd_wren", 32'(mwren[0]), 32'd0);
            end
            for (int i = 0; i < N; i++) begin
                chk($sformatf("raw_rv2_%0d_%0d", i, k), 32'(rvalid_2[i]), 32'(k == lat_of(i)));
                chk($sformatf("raw_rv1_%0d_%0d", i, k), 32'(rvalid_1[i]), 32'd0);
                if (k == lat_of(i))
                    chk($sformatf("raw_data_%0d", i), 32'(rdata[i]), 32'h0000A5A5);
            end
        end

        // Both read continuously for 8 cycles: requester 2 was last, so 1,2,1,2...
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k < 8) drv(1'b1, 1'b0, 10'd0, '0, 1'b1, 1'b0, 10'h3FF, '0);
            else       idle();
            @(negedge clk);
            if (k < 8) begin
                chk($sformatf("alt_gnt1_%0d", k), 32'(gnt_1[0]), 32'(k % 2 == 0));
                chk($sformatf("alt_gnt2_%0d", k), 32'(gnt_2[0]), 32'(k % 2 == 1));
                chk($sformatf("alt_sel_%0d", k),  32'(msel[0]),  32'(k % 2 == 1));
            end
            for (int i = 0; i < N; i++) begin
                int j;
                j = k - lat_of(i);
                if (j >= 0 && j < 8) begin
                    chk($sformatf("alt_rv1_%0d_%0d", i, k), 32'(rvalid_1[i]), 32'(j % 2 == 0));
                    chk($sformatf("alt_rv2_%0d_%0d", i, k), 32'(rvalid_2[i]), 32'(j % 2 == 1));
                    chk($sformatf("alt_data_%0d_%0d", i, k), 32'(rdata[i]),
                        (j % 2 == 0) ? 32'h00000001 : 32'h0000A5A5);
                end else begin
                    chk($sformatf("alt_idle_%0d_%0d", i, k), 32'(rvalid_1[i] | rvalid_2[i]), 32'd0);
                end
            end
        end

        // Four back-to-back reads of addresses 0..3 by requester 1
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k < 4) drv(1'b1, 1'b0, AW'(k), '0, 1'b0, 1'b0, '0, '0);
            else       idle();
            @(negedge clk);
            if (k < 4) chk($sformatf("brst_gnt1_%0d", k), 32'(gnt_1[0]), 32'd1);
            for (int i = 0; i < N; i++) begin
                int j;
                j = k - lat_of(i);
                chk($sformatf("brst_rv1_%0d_%0d", i, k), 32'(rvalid_1[i]), 32'(j >= 0 && j < 4));
                if (j >= 0 && j < 4)
                    chk($sformatf("brst_data_%0d_%0d", i, k), 32'(rdata[i]), 32'(j + 1));
            end
        end

        // Reset one cycle after a read grant drops that read
        tick();
        drv(1'b1, 1'b0, 10'd2, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("mrst_gnt1", 32'(gnt_1[0]), 32'd1);
        tick();
        n_rst = 1'b0;
        idle();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("mrst_busy_%0d", i), 32'(busy[i]), 32'd0);
            chk($sformatf("mrst_rv1_%0d", i), 32'(rvalid_1[i]), 32'd0);
        end
        tick();
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("post_rv1_%0d_%0d", i, k), 32'(rvalid_1[i]), 32'd0);
                chk($sformatf("post_busy_%0d_%0d", i, k), 32'(busy[i]), 32'd0);
            end
            tick();
        end
        // Requester 1 was last before reset; reset must hand it the win again
        drv(1'b1, 1'b1, 10'd0, 16'h0001, 1'b1, 1'b1, 10'd1, 16'h0002);
        @(negedge clk);
        chk("post_gnt1", 32'(gnt_1[0]), 32'd1);
        chk("post_gnt2", 32'(gnt_2[0]), 32'd0);
        tick();
        drv(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'd1, 16'h0002);
        @(negedge clk);
        chk("post_next_gnt2", 32'(gnt_2[0]), 32'd1);

`ifdef PIXEL_ARB_LOCK_EN
        // Requester 2 locks through a 5-cycle contention, then releases
        tick();
        drv(1'b1, 1'b1, 10'd0, 16'h0001, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("lk_pre_gnt1", 32'(gnt_1[0]), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            lock_2 = (k < 5);
            drv(1'b1, 1'b1, 10'd0, 16'h0001, 1'b1, 1'b1, 10'd1, 16'h0002);
            @(negedge clk);
            chk($sformatf("lk_gnt2_%0d", k), 32'(gnt_2[0]), 32'(k < 5));
            chk($sformatf("lk_gnt1_%0d", k), 32'(gnt_1[0]), 32'(k == 5));
        end
        lock_2 = 1'b0;
`endif

        tick();
        idle();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
